// File: rtl/mux_rr_stream_if.sv
// Stream bundle between N_CH producers, the multiplexer and one shared consumer.
// The master side drives channel data and consumer ready; the slave side is the mux.
interface mux_rr_stream_if #(
    parameter int N_CH = 4,
    parameter int DW   = 4,
    localparam int SELW = $clog2(N_CH)
);
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH*DW-1:0]   in_data;
    logic [N_CH-1:0]      in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_rr_stream.sv
// N-channel stream multiplexer with a one-word output register, fixed-select or
// round-robin grant, and a source-channel tag on every output word.
module mux_rr_stream #(
    parameter int N_CH = 4,
    parameter int DW   = 4,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    mux_rr_stream_if.slave      bus
);
    typedef enum logic {EMPTY, FULL} state_e;

    localparam logic [SELW-1:0] LAST_CH = SELW'(N_CH - 1);

    state_e            state_q, state_d;
    logic [DW-1:0]     data_q,  data_d;
    logic [SELW-1:0]   ch_q,    ch_d;
    logic [SELW-1:0]   ptr_q,   ptr_d;

    logic              load_en;
    logic              found;
    logic [SELW-1:0]   cand;
    logic              grant;
    logic              xfer;
    logic [N_CH-1:0]   in_ready_s;
    int                idx;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        load_en    = (state_q == EMPTY) || bus.out_ready;
        found      = 1'b0;
        cand       = '0;
        idx        = 0;
        in_ready_s = '0;
        xfer       = 1'b0;

        if (!bus.mode) begin
            // Non-power-of-two channel counts leave some sel codes unmapped.
            if (int'(bus.sel) < N_CH) begin
                found = 1'b1;
                cand  = bus.sel;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!found && bus.in_valid[idx]) begin
                    found = 1'b1;
                    cand  = SELW'(idx);
                end
            end
        end

        grant = found && load_en && !rst;
        for (int k = 0; k < N_CH; k++) begin
            in_ready_s[k] = grant && (cand == SELW'(k));
            if (in_ready_s[k] && bus.in_valid[k]) xfer = 1'b1;
        end

        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = bus.in_data[cand*DW +: DW];
            ch_d    = cand;
            if (bus.mode) ptr_d = (cand == LAST_CH) ? '0 : cand + 1'b1;
        end else if (load_en) begin
            state_d = EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_mux_rr_stream.sv
// Self-checking bench for mux_rr_stream: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mux_rr_stream;
    localparam int N_CH = 4;
    localparam int DW   = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: the output word and the round-robin pointer.
    bit   m_valid;
    int   m_data;
    int   m_ch;
    int   m_ptr;

    mux_rr_stream_if #(.N_CH(N_CH), .DW(DW)) bus ();

    mux_rr_stream #(.N_CH(N_CH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_data(input int d0, input int d1, input int d2, input int d3);
        bus.in_data = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic step();
        bit   found;
        bit   ld;
        int   cand;
        int   k;
        logic [N_CH-1:0] exp_rdy;
        @(negedge clk);
        ld    = !m_valid || bus.out_ready;
        found = 0;
        cand  = 0;
        if (bus.mode == 1'b0) begin
            if (int'(bus.sel) < N_CH) begin
                found = 1;
                cand  = int'(bus.sel);
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                k = (m_ptr + i) % N_CH;
                if (!found && bus.in_valid[k]) begin
                    found = 1;
                    cand  = k;
                end
            end
        end
        exp_rdy = (found && ld && !rst) ? N_CH'(1 << cand) : '0;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (exp_rdy != '0 && bus.in_valid[cand]) begin
            m_valid = 1;
            m_data  = int'(bus.in_data[cand*DW +: DW]);
            m_ch    = cand;
            if (bus.mode) m_ptr = (cand + 1) % N_CH;
        end else if (ld) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data",  32'(bus.out_data),  32'(m_data));
        check("out_ch",    32'(bus.out_ch),    32'(m_ch));
    endtask

    initial begin
        rst = 1'b1;
        bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        @(posedge clk); #1;

        // Reset held for two clocks.
        step(); step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;

        // Fixed select of channel 2.
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
        set_data(0, 0, 4'hA, 0);
        step();
        check("fixed_data", 32'(bus.out_data), 32'hA);
        check("fixed_ch", 32'(bus.out_ch), 32'd2);
        step();

        // Round-robin fairness with all channels valid.
        bus.mode = 1'b1; bus.in_valid = 4'b1111; set_data(5, 6, 7, 8);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_order_ch", 32'(bus.out_ch), 32'(i % N_CH));
            check("rr_order_data", 32'(bus.out_data), 32'(5 + i % N_CH));
        end

        // Move pointer to 3, then wrap through ch0, ch1 and back to ch3.
        bus.in_valid = 4'b0100; step();
        bus.in_valid = 4'b0011; step();
        check("wrap_ch0", 32'(bus.out_ch), 32'd0);
        step();
        check("wrap_ch1", 32'(bus.out_ch), 32'd1);
        bus.in_valid = 4'b1000; step();
        check("wrap_ch3", 32'(bus.out_ch), 32'd3);

        // Stall a FULL register holding 6 while inputs toggle.
        bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b0010; set_data(0, 6, 0, 0);
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 4'($urandom); bus.in_data = 16'($urandom);
            bus.mode = 1'($urandom); bus.sel = 2'($urandom);
            step();
            check("stall_data", 32'(bus.out_data), 32'd6);
            check("stall_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.mode = 1'b0; bus.sel = 2'd3; bus.in_valid = 4'b1000; set_data(0, 0, 0, 9);
        bus.out_ready = 1'b1;
        step();
        check("unstall_load", 32'(bus.out_data), 32'd9);

        // Reset while FULL and stalled; round-robin restarts at ch0.
        bus.mode = 1'b1; bus.in_valid = 4'b0100; step();
        bus.out_ready = 1'b0; step();
        rst = 1'b1; step();
        check("rst_full_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 4'b1111; set_data(1, 2, 3, 4);
        step();
        check("rst_restart_ch", 32'(bus.out_ch), 32'd0);

        // Random traffic, including mode switches and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) bus.mode = 1'($urandom);
            bus.sel       = 2'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
